fb_rect_fill: RTL and testbench



---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_raster_cnt.sv | 79 +++++++
 rtl/fb_rect_fill.sv | 161 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared display constants, fill-engine states and row-base helper
//
// Imported by fb_rect_fill, fb_raster_cnt and the VGA scan-out block, so the
// framebuffer geometry is defined in exactly one place.
//   H_ACTIVE : visible pixels per line, also the RAM row stride in words
//   V_ACTIVE : visible lines per frame
//   ADDR_W   : display RAM address width
//   COL_W    : pixel width, RGB444 {R[11:8],G[7:4],B[3:0]}
package fb_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int COL_W    = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } fb_state_t;

    // y*640 as (y<<9)+(y<<7); keeps a multiplier out of the address path.
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [8:0] y);
        logic [ADDR_W-1:0] w_y;
        w_y = {10'd0, y};
        return (w_y << 9) + (w_y << 7);
    endfunction

endpackage

// File: rtl/fb_raster_cnt.sv
// rtl/fb_raster_cnt.sv - raster column/row counters with row-base address register
//
// Walks a w x h rectangle in raster order and supplies write addresses.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_load        : latch origin and size, restart at pixel (0,0)
//   i_step        : advance to the next pixel
//   i_x, i_y      : rectangle origin (used on i_load)
//   i_w, i_h      : rectangle size, both non-zero when loaded
//   o_first_addr  : address of the origin pixel, from i_x/i_y
//   o_next_addr   : address of the pixel after the current one
//   o_last        : current pixel is the final one of the rectangle
module fb_raster_cnt
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic [9:0]        i_w,
    input  logic [8:0]        i_h,
    output logic [ADDR_W-1:0] o_first_addr,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_ACTIVE);

    logic [9:0]        r_col;
    logic [8:0]        r_row;
    logic [9:0]        r_x;
    logic [9:0]        r_w;
    logic [8:0]        r_h;
    logic [ADDR_W-1:0] r_row_base;

    logic              w_col_end;
    logic              w_row_end;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_col_ext;

    assign w_col_end = (r_col == r_w - 10'd1);
    assign w_row_end = (r_row == r_h - 9'd1);
    assign w_x_ext   = {9'd0, r_x};
    assign w_col_ext = {9'd0, r_col};

    assign o_first_addr = row_base_of(i_y) + {9'd0, i_x};
    assign o_next_addr  = w_col_end ? (r_row_base + STRIDE + w_x_ext)
                                    : (r_row_base + w_x_ext + w_col_ext + 1'b1);
    assign o_last       = w_col_end && w_row_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_x        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_row_base <= '0;
        end else if (i_load) begin
            r_col      <= '0;
            r_row      <= '0;
            r_x        <= i_x;
            r_w        <= i_w;
            r_h        <= i_h;
            r_row_base <= row_base_of(i_y);
        end else if (i_step) begin
            if (w_col_end) begin
                r_col      <= '0;
                r_row      <= r_row + 9'd1;
                r_row_base <= r_row_base + STRIDE;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - rectangle-fill write engine for the 640x480 RGB444 display RAM
//
// Accepts one fill command at a time and writes one pixel per clock.
// Optional build macro FB_CLIP_EN: clip off-screen rectangles instead of rejecting them.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake, accepted on cmd_valid && cmd_ready
//   cmd_x, cmd_y      : rectangle origin
//   cmd_w, cmd_h      : rectangle size
//   cmd_colour        : fill colour
//   ram_addra/dina/wea: display RAM write port
//   busy              : pixel writes in progress
//   done              : one-cycle pulse when a command completes
//   err               : one-cycle pulse when a command is rejected
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [COL_W-1:0]  cmd_colour,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [COL_W-1:0]  ram_dina,
    output logic              ram_wea,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    fb_state_t         r_state;

    logic [10:0]       w_x_end;
    logic [9:0]        w_y_end;
    logic [9:0]        w_eff_w;
    logic [8:0]        w_eff_h;
    logic              w_reject;
    logic              w_empty;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_first_addr;
    logic [ADDR_W-1:0] w_next_addr;

    // Range sums are one bit wider than the operands so they cannot wrap.
    assign w_x_end = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign w_y_end = {1'b0, cmd_y} + {1'b0, cmd_h};

`ifdef FB_CLIP_EN
    logic [10:0] w_x_room;
    logic [9:0]  w_y_room;

    assign w_x_room = H_LIM - {1'b0, cmd_x};
    assign w_y_room = V_LIM - {1'b0, cmd_y};

    always_comb begin
        w_reject = 1'b0;
        w_eff_w  = cmd_w;
        w_eff_h  = cmd_h;
        if ({1'b0, cmd_x} >= H_LIM) begin
            w_eff_w = '0;
        end else if (w_x_end > H_LIM) begin
            w_eff_w = w_x_room[9:0];
        end
        if ({1'b0, cmd_y} >= V_LIM) begin
            w_eff_h = '0;
        end else if (w_y_end > V_LIM) begin
            w_eff_h = w_y_room[8:0];
        end
    end
`else
    always_comb begin
        w_eff_w  = cmd_w;
        w_eff_h  = cmd_h;
        w_reject = (w_x_end > H_LIM) || (w_y_end > V_LIM);
    end
`endif

    assign w_empty = (w_eff_w == '0) || (w_eff_h == '0);
    assign w_load  = (r_state == IDLE) && cmd_valid;
    assign w_step  = (r_state == FILL) && !w_last;

    fb_raster_cnt u_raster_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_x          (cmd_x),
        .i_y          (cmd_y),
        .i_w          (w_eff_w),
        .i_h          (w_eff_h),
        .o_first_addr (w_first_addr),
        .o_next_addr  (w_next_addr),
        .o_last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (w_reject) begin
                            // Stay in IDLE: err and cmd_ready are both high next cycle.
                            err <= 1'b1;
                        end else if (w_empty) begin
                            r_state   <= FINISH;
                            cmd_ready <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            r_state   <= FILL;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            ram_wea   <= 1'b1;
                            ram_addra <= w_first_addr;
                            ram_dina  <= cmd_colour;
                        end
                    end
                end
                FILL: begin
                    if (w_last) begin
                        r_state <= FINISH;
                        busy    <= 1'b0;
                        ram_wea <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        ram_addra <= w_next_addr;
                    end
                end
                FINISH: begin
                    r_state   <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    ram_wea   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - directed vector bench for fb_rect_fill
module tb_fb_rect_fill;
    import fb_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [9:0]        cmd_x = '0;
    logic [8:0]        cmd_y = '0;
    logic [9:0]        cmd_w = '0;
    logic [8:0]        cmd_h = '0;
    logic [COL_W-1:0]  cmd_colour = '0;
    logic [ADDR_W-1:0] ram_addra;
    logic [COL_W-1:0]  ram_dina;
    logic              ram_wea;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    fb_rect_fill dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_wea    (ram_wea),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int w; int h; int col;
        int ew;                 // effective width used for the address model
        int n_wr; int first_a; int last_a;
        bit exp_done; bit exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int nwr = 0, busy_n = 0, done_n = 0, err_n = 0, bad = 0;
        int done_c = 0, err_c = 0, first_c = 0, last_c = 0;
        int first_a = -1, last_a = -1, rdy_after = -1;
        int win;
        win = v.n_wr + 5;
        @(negedge clk);
        check($sformatf("v%0d ready_idle", id), int'(cmd_ready), 1);
        cmd_x      = v.x[9:0];
        cmd_y      = v.y[8:0];
        cmd_w      = v.w[9:0];
        cmd_h      = v.h[8:0];
        cmd_colour = v.col[11:0];
        cmd_valid  = 1'b1;
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (ram_wea) begin
                int ea;
                ea = (v.y + nwr / v.ew) * H_ACTIVE + v.x + nwr % v.ew;
                if (int'(ram_addra) != ea || int'(ram_dina) != v.col) bad++;
                if (nwr == 0) begin first_c = c; first_a = int'(ram_addra); end
                last_c = c;
                last_a = int'(ram_addra);
                nwr++;
            end
            if (busy) busy_n++;
            if (done) begin done_n++; if (done_c == 0) done_c = c; end
            if (err) begin err_n++; if (err_c == 0) err_c = c; end
            if (done_c != 0 && c == done_c + 1) rdy_after = int'(cmd_ready);
        end
        check($sformatf("v%0d writes", id), nwr, v.n_wr);
        check($sformatf("v%0d bad_writes", id), bad, 0);
        check($sformatf("v%0d first_addr", id), first_a, v.first_a);
        check($sformatf("v%0d last_addr", id), last_a, v.last_a);
        check($sformatf("v%0d first_wr_cycle", id), first_c, (v.n_wr > 0) ? 1 : 0);
        check($sformatf("v%0d last_wr_cycle", id), last_c, v.n_wr);
        check($sformatf("v%0d busy_cycles", id), busy_n, v.n_wr);
        check($sformatf("v%0d done_count", id), done_n, v.exp_done ? 1 : 0);
        check($sformatf("v%0d done_cycle", id), done_c, v.exp_done ? v.n_wr + 1 : 0);
        check($sformatf("v%0d err_count", id), err_n, v.exp_err ? 1 : 0);
        check($sformatf("v%0d err_cycle", id), err_c, v.exp_err ? 1 : 0);
        if (v.exp_done) check($sformatf("v%0d ready_after_done", id), rdy_after, 1);
    endtask

    initial begin
        int nwr, bad, done_c, rdy_bad, b_c, b_a, b_d, wr_n, dn_n;

        // x, y, w, h, colour, eff_w, n_wr, first, last, done, err
        vecs[0] = '{0,   0,   4,   2,  'hF00, 4,   8,   0,      643,    1'b1, 1'b0};
        vecs[1] = '{639, 479, 1,   1,  'h0F0, 1,   1,   307199, 307199, 1'b1, 1'b0};
        vecs[2] = '{5,   5,   0,   5,  'h123, 1,   0,   -1,     -1,     1'b1, 1'b0};
        vecs[4] = '{10,  3,   3,   3,  'h00F, 3,   9,   1930,   3212,   1'b1, 1'b0};
        vecs[7] = '{0,   0,   640, 1,  'hFFF, 640, 640, 0,      639,    1'b1, 1'b0};
`ifdef FB_CLIP_EN
        vecs[3] = '{636, 0,   8,   1,  'h0AF, 8,   4,   636,    639,    1'b1, 1'b0};
        vecs[5] = '{0,   470, 2,   20, 'hA5A, 2,   20,  300800, 306561, 1'b1, 1'b0};
        vecs[6] = '{700, 0,   1,   1,  'h777, 1,   0,   -1,     -1,     1'b1, 1'b0};
`else
        vecs[3] = '{636, 0,   8,   1,  'h0AF, 8,   0,   -1,     -1,     1'b0, 1'b1};
        vecs[5] = '{0,   470, 2,   20, 'hA5A, 2,   0,   -1,     -1,     1'b0, 1'b1};
        vecs[6] = '{700, 0,   1,   1,  'h777, 1,   0,   -1,     -1,     1'b0, 1'b1};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              int'({cmd_ready, busy, done, err, ram_wea}), int'(5'b10000));
        check("reset_addr_data", int'(ram_addra) + int'(ram_dina), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // cmd_valid held with new data throughout a 3x3 fill at (20,10)
        @(negedge clk);
        cmd_x = 10'd20; cmd_y = 9'd10; cmd_w = 10'd3; cmd_h = 9'd3;
        cmd_colour = 12'hABC; cmd_valid = 1'b1;
        nwr = 0; bad = 0; done_c = 0; rdy_bad = 0; b_c = 0; b_a = -1; b_d = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1;
                cmd_colour = 12'h111;
            end
            if (ram_wea) begin
                if (c <= 9) begin
                    if (int'(ram_addra) != (10 + nwr / 3) * H_ACTIVE + 20 + nwr % 3 ||
                        ram_dina != 12'hABC) bad++;
                    nwr++;
                end else if (b_c == 0) begin
                    b_c = c; b_a = int'(ram_addra); b_d = int'(ram_dina);
                end
            end
            if (done && done_c == 0) done_c = c;
            if (c <= 10 && cmd_ready) rdy_bad++;
            if (c == 12) cmd_valid = 1'b0;
        end
        check("hold_first_writes", nwr, 9);
        check("hold_first_bad", bad, 0);
        check("hold_first_done", done_c, 10);
        check("hold_ready_low", rdy_bad, 0);
        check("hold_second_cycle", b_c, 12);
        check("hold_second_addr", b_a, 0);
        check("hold_second_data", b_d, 'h111);

        // Reset at the 3rd write of a 4x4 fill
        @(negedge clk);
        cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd4; cmd_h = 9'd4;
        cmd_colour = 12'h0AA; cmd_valid = 1'b1;
        wr_n = 0; dn_n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (c <= 3 && ram_wea) wr_n++;
            if (c == 4) begin
                check("rst_wea_off", int'(ram_wea), 0);
                check("rst_busy_off", int'(busy), 0);
            end
            if (c >= 4 && ram_wea) wr_n += 100;
            if (done) dn_n++;
            if (c == 3) rst = 1'b1;
            if (c == 5) rst = 1'b0;
        end
        check("rst_writes_before", wr_n, 3);
        check("rst_no_done", dn_n, 0);
        check("rst_ready_after", int'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
